// File: rtl/split_bus_pkg.sv
// Shared definitions for the serial split bus: widths, bus field encodings and
// the initiator port state encoding.
package split_bus_pkg;

    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ACK_TIMEOUT = 64;

    localparam logic BUS_MODE_ADDR = 1'b0;
    localparam logic BUS_MODE_DATA = 1'b1;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_ADDR       = 3'd2,
        ST_WDATA      = 3'd3,
        ST_WAIT_ACK   = 3'd4,
        ST_RDATA      = 3'd5,
        ST_SPLIT_WAIT = 3'd6
    } state_e;

endpackage

// File: rtl/split_init_shifter.sv
// LSB-first parallel-in/serial-out shifter shared by the address and write-data phases.
// o_bit is the bit to put on the wire this cycle; o_last marks the final bit of the load.
module split_init_shifter
    import split_bus_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_last_idx,
    input  logic             i_shift,
    output logic             o_bit,
    output logic             o_last
);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_last_idx <= '0;
        end else if (i_load) begin
            r_shreg    <= i_data;
            r_cnt      <= '0;
            r_last_idx <= i_last_idx;
        end else if (i_shift) begin
            // Counter returns to zero after the final bit so the next load starts clean.
            r_shreg <= r_shreg >> 1;
            r_cnt   <= o_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_bit  = r_shreg[0];
    assign o_last = (r_cnt == r_last_idx);

endmodule

// File: rtl/split_initiator_port.sv
// Initiator side of the serial split bus: arbitrates, serializes address and
// write data, then collects the write ack or the (possibly split) read data.
module split_initiator_port
    import split_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_wdata,
    input  logic                  init_rw,
    output logic                  init_busy,
    output logic [DATA_WIDTH-1:0] init_rdata,
    output logic                  init_rdata_valid,
    output logic                  init_done,
    output logic                  init_error,
    output logic                  arbiter_req,
    input  logic                  arbiter_grant,
    input  logic                  split_grant,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  bus_mode,
    output logic                  bus_rw,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid,
    input  logic                  bus_target_ready,
    input  logic                  bus_target_ack,
    input  logic                  bus_split_ack,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE       = ST_IDLE;
    localparam logic [2:0] S_REQ        = ST_REQ;
    localparam logic [2:0] S_ADDR       = ST_ADDR;
    localparam logic [2:0] S_WDATA      = ST_WDATA;
    localparam logic [2:0] S_WAIT_ACK   = ST_WAIT_ACK;
    localparam logic [2:0] S_RDATA      = ST_RDATA;
    localparam logic [2:0] S_SPLIT_WAIT = ST_SPLIT_WAIT;

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int SH_CW = $clog2(ADDR_WIDTH + 1);
    localparam int RD_CW = $clog2(DATA_WIDTH);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rw;
    logic [TMR_W-1:0]      r_timer;
    logic [RD_CW-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rd_shift;

    logic                  w_start;
    logic                  w_sh_load;
    logic                  w_sh_shift;
    logic                  w_sh_bit;
    logic                  w_sh_last;
    logic [ADDR_WIDTH-1:0] w_sh_data;
    logic [SH_CW-1:0]      w_sh_last_idx;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_rd_next;

    always_comb begin
        w_start       = (r_state == S_REQ) && arbiter_grant && bus_target_ready;
        // The data phase is loaded on the same edge that emits the last address bit.
        w_sh_load     = w_start || ((r_state == S_ADDR) && arbiter_grant && w_sh_last
                                    && (r_rw == RW_WRITE));
        w_sh_data     = w_start ? r_addr : ADDR_WIDTH'(r_wdata);
        w_sh_last_idx = w_start ? SH_CW'(ADDR_WIDTH - 1) : SH_CW'(DATA_WIDTH - 1);
        w_sh_shift    = ((r_state == S_ADDR) || (r_state == S_WDATA)) && arbiter_grant;
        w_timeout     = (r_timer == TMR_W'(ACK_TIMEOUT - 1));
        w_rd_next     = r_rd_shift;
        w_rd_next[r_bit_cnt] = bus_data_in;
    end

    split_init_shifter #(
        .WIDTH (ADDR_WIDTH),
        .CNT_W (SH_CW)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_sh_load),
        .i_data     (w_sh_data),
        .i_last_idx (w_sh_last_idx),
        .i_shift    (w_sh_shift),
        .o_bit      (w_sh_bit),
        .o_last     (w_sh_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_addr             <= '0;
            r_wdata            <= '0;
            r_rw               <= 1'b0;
            r_timer            <= '0;
            r_bit_cnt          <= '0;
            r_rd_shift         <= '0;
            init_busy          <= 1'b0;
            init_rdata         <= '0;
            init_rdata_valid   <= 1'b0;
            init_done          <= 1'b0;
            init_error         <= 1'b0;
            arbiter_req        <= 1'b0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= BUS_MODE_ADDR;
            bus_rw             <= 1'b0;
        end else begin
            init_done          <= 1'b0;
            init_error         <= 1'b0;
            init_rdata_valid   <= 1'b0;
            bus_data_out       <= 1'b0;
            bus_data_out_valid <= 1'b0;
            bus_mode           <= BUS_MODE_ADDR;

            case (r_state)
                S_IDLE: begin
                    if (init_req) begin
                        r_addr      <= init_addr;
                        r_wdata     <= init_wdata;
                        r_rw        <= init_rw;
                        bus_rw      <= init_rw;
                        arbiter_req <= 1'b1;
                        init_busy   <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_start) r_state <= S_ADDR;
                end
                S_ADDR, S_WDATA: begin
                    if (!arbiter_grant) begin
                        init_error  <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        bus_data_out_valid <= 1'b1;
                        bus_data_out       <= w_sh_bit;
                        bus_mode           <= (r_state == S_WDATA) ? BUS_MODE_DATA : BUS_MODE_ADDR;
                        if (w_sh_last) begin
                            r_timer   <= '0;
                            r_bit_cnt <= '0;
                            if (r_state == S_WDATA)      r_state <= S_WAIT_ACK;
                            else if (r_rw == RW_WRITE)   r_state <= S_WDATA;
                            else                         r_state <= S_RDATA;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (bus_target_ack) begin
                        init_done   <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_timeout) begin
                        init_error  <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_RDATA: begin
                    // A received bit outranks a split offered in the same cycle.
                    if (bus_data_in_valid) begin
                        r_rd_shift <= w_rd_next;
                        r_bit_cnt  <= r_bit_cnt + RD_CW'(1);
                        r_timer    <= '0;
                        if (r_bit_cnt == RD_CW'(DATA_WIDTH - 1)) begin
                            init_rdata       <= w_rd_next;
                            init_rdata_valid <= 1'b1;
                            init_done        <= 1'b1;
                            arbiter_req      <= 1'b0;
                            init_busy        <= 1'b0;
                            r_state          <= S_IDLE;
                        end
                    end else if (bus_split_ack && (r_bit_cnt == '0)) begin
                        arbiter_req <= 1'b0;
                        r_state     <= S_SPLIT_WAIT;
                    end else if (w_timeout) begin
                        init_error  <= 1'b1;
                        arbiter_req <= 1'b0;
                        init_busy   <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_SPLIT_WAIT: begin
                    if (split_grant) begin
                        r_bit_cnt <= '0;
                        r_timer   <= '0;
                        r_state   <= S_RDATA;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_split_initiator_port.sv
// Randomized bench for split_initiator_port: drivers push expected serial bits and
// completions into queues, a negedge monitor pops and compares them.
module tb_split_initiator_port;
    import split_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic [15:0] init_addr = '0;
    logic [7:0]  init_wdata = '0;
    logic        init_rw = 1'b0;
    logic        init_busy;
    logic [7:0]  init_rdata;
    logic        init_rdata_valid;
    logic        init_done;
    logic        init_error;
    logic        arbiter_req;
    logic        arbiter_grant = 1'b0;
    logic        split_grant = 1'b0;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_mode;
    logic        bus_rw;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_target_ready = 1'b0;
    logic        bus_target_ack = 1'b0;
    logic        bus_split_ack = 1'b0;
    logic [2:0]  dbg_state;

    split_initiator_port dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_req           (init_req),
        .init_addr          (init_addr),
        .init_wdata         (init_wdata),
        .init_rw            (init_rw),
        .init_busy          (init_busy),
        .init_rdata         (init_rdata),
        .init_rdata_valid   (init_rdata_valid),
        .init_done          (init_done),
        .init_error         (init_error),
        .arbiter_req        (arbiter_req),
        .arbiter_grant      (arbiter_grant),
        .split_grant        (split_grant),
        .bus_data_out       (bus_data_out),
        .bus_data_out_valid (bus_data_out_valid),
        .bus_mode           (bus_mode),
        .bus_rw             (bus_rw),
        .bus_data_in        (bus_data_in),
        .bus_data_in_valid  (bus_data_in_valid),
        .bus_target_ready   (bus_target_ready),
        .bus_target_ack     (bus_target_ack),
        .bus_split_ack      (bus_split_ack),
        .dbg_state          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    localparam logic [1:0] EV_WDONE = 2'd1;
    localparam logic [1:0] EV_RDONE = 2'd2;
    localparam logic [1:0] EV_ERROR = 2'd3;

    logic [1:0]  exp_bit_q[$];   // {bus_mode, bus_data_out}
    logic [25:0] exp_evt_q[$];   // {kind, rdata, latency after last bus bit (0 = unchecked)}
    logic        exp_rw = 1'b0;
    int          last_bit_cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_unexp(input string name);
        n_checks++;
        $display("FAIL %s: got an unexpected output, required none (cycle %0d)", name, cyc);
    endtask

    logic [1:0]  m_bit;
    logic [25:0] m_evt;
    logic [1:0]  m_kind;

    always @(negedge clk) begin
        if (bus_data_out_valid) begin
            last_bit_cyc = cyc;
            if (exp_bit_q.size() == 0) fail_unexp("bus_bit");
            else begin
                m_bit = exp_bit_q.pop_front();
                check("bus_bit", 32'({bus_mode, bus_data_out}), 32'(m_bit));
                check("bus_rw", 32'(bus_rw), 32'(exp_rw));
            end
        end
        if (init_done || init_error || init_rdata_valid) begin
            m_kind = init_error ? EV_ERROR :
                     (init_done && init_rdata_valid) ? EV_RDONE :
                     init_done ? EV_WDONE : 2'd0;
            check("done_error_exclusive", 32'(init_done & init_error), 32'd0);
            if (exp_evt_q.size() == 0) fail_unexp("completion");
            else begin
                m_evt = exp_evt_q.pop_front();
                check("evt_kind", 32'(m_kind), 32'(m_evt[25:24]));
                if (m_evt[25:24] == EV_RDONE) check("rdata", 32'(init_rdata), 32'(m_evt[23:16]));
                if (m_evt[15:0] != 16'd0) check("evt_latency", 32'(cyc - last_bit_cyc), 32'(m_evt[15:0]));
            end
        end
    end

    // ---------------- reference model ----------------
    // Serial order: address LSB first in mode 0, then (writes only) data LSB first in mode 1.
    task automatic push_bits(input logic [15:0] a, input logic [7:0] wd, input int n);
        logic [15:0] av;
        logic [7:0]  dv;
        av = a;
        dv = wd;
        for (int i = 0; i < n; i++) begin
            if (i < 16) exp_bit_q.push_back({BUS_MODE_ADDR, av[i]});
            else        exp_bit_q.push_back({BUS_MODE_DATA, dv[i-16]});
        end
    endtask

    task automatic push_evt(input logic [1:0] kind, input logic [7:0] data, input int lat);
        exp_evt_q.push_back({kind, data, 16'(lat)});
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({init_busy, init_rdata, init_rdata_valid, init_done, init_error, arbiter_req,
                    bus_data_out, bus_data_out_valid, bus_mode, bus_rw});
    endfunction

    task automatic issue(input logic [15:0] a, input logic [7:0] wd, input logic rw, input int gdly);
        exp_rw     = rw;
        init_addr  = a;
        init_wdata = wd;
        init_rw    = rw;
        init_req   = 1'b1;
        step();
        init_req   = 1'b0;
        init_addr  = ~a;
        init_wdata = ~wd;
        init_rw    = ~rw;
        check("req_busy_after_accept", 32'({arbiter_req, init_busy}), 32'b11);
        for (int i = 0; i < gdly; i++) begin
            arbiter_grant    = 1'($urandom_range(0, 1));
            bus_target_ready = ~arbiter_grant;
            step();
        end
        arbiter_grant    = 1'b1;
        bus_target_ready = 1'b1;
    endtask

    task automatic wait_bits(input int n);
        int cnt = 0;
        int guard = 0;
        while (cnt < n && guard < 400) begin
            step();
            guard++;
            if (bus_data_out_valid) cnt++;
        end
        check("bus_bits_seen", 32'(cnt), 32'(n));
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_evt_q.size() != 0 && guard < 300) begin
            step();
            guard++;
        end
        check("completion_arrived", 32'(exp_evt_q.size()), 32'd0);
    endtask

    task automatic end_bus();
        arbiter_grant    = 1'b0;
        bus_target_ready = 1'b0;
        step();
        check("idle_after_txn", 32'({arbiter_req, init_busy}), 32'd0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] wd, input int gdly, input int ack_dly);
        push_bits(a, wd, 24);
        push_evt(EV_WDONE, 8'h00, ack_dly);
        issue(a, wd, 1'b1, gdly);
        wait_bits(24);
        for (int i = 1; i < ack_dly; i++) begin
            bus_split_ack = 1'($urandom_range(0, 1));
            step();
        end
        bus_split_ack  = 1'b0;
        bus_target_ack = 1'b1;
        step();
        bus_target_ack = 1'b0;
        drain();
        end_bus();
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] rd, input int gdly, input int d0,
                           input int gap, input int split_dly, input int split_idle,
                           input bit simult, input bit mid);
        logic [7:0] rv;
        rv = rd;
        push_bits(a, 8'h00, 16);
        push_evt(EV_RDONE, rd, 0);
        issue(a, 8'h00, 1'b0, gdly);
        wait_bits(16);
        if (split_dly >= 0) begin
            repeat (split_dly) step();
            bus_split_ack = 1'b1;
            step();
            bus_split_ack = 1'b0;
            check("req_drop_on_split", 32'({arbiter_req, init_busy}), 32'b01);
            for (int i = 0; i < split_idle; i++) begin
                bus_data_in_valid = (i == split_idle / 2);
                bus_data_in       = 1'b1;
                step();
            end
            bus_data_in_valid = 1'b0;
            bus_data_in       = 1'b0;
            split_grant = 1'b1;
            step();
            split_grant = 1'b0;
            check("req_low_after_split_grant", 32'({arbiter_req, init_busy}), 32'b01);
        end
        repeat (d0) step();
        for (int i = 0; i < 8; i++) begin
            bus_data_in       = rv[i];
            bus_data_in_valid = 1'b1;
            bus_split_ack     = simult && (i == 0);
            step();
            bus_data_in_valid = 1'b0;
            bus_data_in       = 1'b0;
            bus_split_ack     = 1'b0;
            if (mid && i == 3) begin
                bus_split_ack = 1'b1;
                step();
                bus_split_ack = 1'b0;
            end
            repeat (gap) step();
        end
        drain();
        end_bus();
    endtask

    task automatic do_timeout(input logic [15:0] a, input logic [7:0] wd, input logic rw, input bit stray);
        push_bits(a, wd, rw ? 24 : 16);
        push_evt(EV_ERROR, 8'h00, 64);
        issue(a, wd, rw, 0);
        wait_bits(rw ? 24 : 16);
        if (stray) begin
            step();
            init_addr  = 16'($urandom);
            init_wdata = 8'($urandom);
            init_rw    = 1'b1;
            init_req   = 1'b1;
            step();
            init_req   = 1'b0;
        end
        drain();
        end_bus();
    endtask

    task automatic do_grant_drop(input logic [15:0] a, input logic [7:0] wd, input logic rw, input int k);
        push_bits(a, wd, k);
        push_evt(EV_ERROR, 8'h00, 1);
        issue(a, wd, rw, 0);
        wait_bits(k);
        arbiter_grant = 1'b0;
        drain();
        end_bus();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
        int          r;

        rst_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", all_outs(), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();

        do_write(16'hA5C3, 8'h5A, 0, 3);
        do_read(16'h1234, 8'h96, 0, 0, 2, -1, 0, 1'b0, 1'b0);
        do_read(16'h00FF, 8'h3C, 1, 1, 1, 3, 100, 1'b0, 1'b0);
        do_timeout(16'hBEEF, 8'hC4, 1'b1, 1'b1);
        do_write(16'h0F0F, 8'h81, 2, 1);
        do_grant_drop(16'h6D2B, 8'h11, 1'b1, 6);

        // Reset while the fourth write-data bit is on the bus: no completion of any kind.
        push_bits(16'h7E01, 8'hB7, 20);
        issue(16'h7E01, 8'hB7, 1'b1, 0);
        wait_bits(20);
        rst_n = 1'b0;
        step();
        check("reset_mid_outputs", all_outs(), 32'd0);
        check("reset_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n            = 1'b1;
        arbiter_grant    = 1'b0;
        bus_target_ready = 1'b0;
        step();
        do_read(16'h4321, 8'hE2, 0, 2, 0, -1, 0, 1'b1, 1'b1);

        for (int t = 0; t < 24; t++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            d  = 8'($urandom);
            r  = $urandom_range(0, 9);
            if (r == 0)      do_timeout(a, d, rw, 1'($urandom_range(0, 1)));
            else if (r == 1) do_grant_drop(a, d, rw, $urandom_range(1, rw ? 23 : 15));
            else if (rw)     do_write(a, d, $urandom_range(0, 3), $urandom_range(1, 10));
            else             do_read(a, d, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
                                     $urandom_range(5, 20), 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)));
        end

        repeat (5) step();
        check("bit_queue_empty", 32'(exp_bit_q.size()), 32'd0);
        check("evt_queue_empty", 32'(exp_evt_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
